// File: rtl/addr_map_pkg.sv
// Shared address-map constants and the inclusive range compare used by the region decoder.
package addr_map_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_SHIFT = 2;
    // Widest address the range compare supports; narrower addresses are zero-extended.
    localparam int unsigned MAX_ADDR_W = 64;

    localparam logic [ADDR_W-1:0] PROG_BASE  = 32'h0000_18C0;
    localparam logic [ADDR_W-1:0] PROG_LIMIT = 32'h0000_1CBF;
    localparam logic [ADDR_W-1:0] DATA_BASE  = 32'h0000_1CC0;
    localparam logic [ADDR_W-1:0] DATA_LIMIT = 32'h0000_20BF;

    function automatic logic in_range(input logic [MAX_ADDR_W-1:0] addr,
                                      input logic [MAX_ADDR_W-1:0] base,
                                      input logic [MAX_ADDR_W-1:0] limit);
        return (addr >= base) && (addr <= limit);
    endfunction

endpackage

// File: rtl/addr_region_match.sv
// Combinational match of one address against one region: hit flag and word offset.
module addr_region_match #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned IDX_W      = 10,
    parameter int unsigned WORD_SHIFT = 2
) (
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] limit_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  index_o
);
    import addr_map_pkg::in_range;

    localparam int unsigned CmpW = addr_map_pkg::MAX_ADDR_W;

    logic [ADDR_W-1:0] offset;

    assign hit_o   = in_range(CmpW'(addr_i), CmpW'(base_i), CmpW'(limit_i));
    // Wraps modulo 2^ADDR_W; upper index bits are dropped without flagging.
    assign offset  = addr_i - base_i;
    assign index_o = IDX_W'(offset >> WORD_SHIFT);

endmodule

// File: rtl/addr_decoding_multi.sv
// Registered multi-region address decoder with valid/ready handshake and fault capture.
module addr_decoding_multi #(
    parameter int unsigned                    ADDR_W       = addr_map_pkg::ADDR_W,
    parameter int unsigned                    NUM_REGIONS  = 2,
    parameter int unsigned                    IDX_W        = 10,
    parameter int unsigned                    WORD_SHIFT   = addr_map_pkg::WORD_SHIFT,
    parameter bit                             ALIGN_CHECK  = 1'b1,
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_BASE  =
        {addr_map_pkg::DATA_BASE, addr_map_pkg::PROG_BASE},
    parameter logic [NUM_REGIONS*ADDR_W-1:0]  REGION_LIMIT =
        {addr_map_pkg::DATA_LIMIT, addr_map_pkg::PROG_LIMIT},
    parameter int unsigned                    CNT_W        = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [ADDR_W-1:0]      req_addr_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [NUM_REGIONS-1:0] rsp_cs_o,
    output logic [IDX_W-1:0]       rsp_index_o,
    output logic                   rsp_err_o,
    input  logic                   fault_clr_i,
    output logic                   fault_valid_o,
    output logic [ADDR_W-1:0]      fault_addr_o,
    output logic [CNT_W-1:0]       fault_cnt_o
);

    logic [NUM_REGIONS-1:0] region_hit;
    logic [IDX_W-1:0]       region_index [NUM_REGIONS];

    for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_region
        addr_region_match #(
            .ADDR_W     (ADDR_W),
            .IDX_W      (IDX_W),
            .WORD_SHIFT (WORD_SHIFT)
        ) u_match (
            .addr_i  (req_addr_i),
            .base_i  (REGION_BASE[r*ADDR_W +: ADDR_W]),
            .limit_i (REGION_LIMIT[r*ADDR_W +: ADDR_W]),
            .hit_o   (region_hit[r]),
            .index_o (region_index[r])
        );
    end

    logic misaligned;
    if (ALIGN_CHECK && (WORD_SHIFT > 0)) begin : g_align
        assign misaligned = |req_addr_i[WORD_SHIFT-1:0];
    end else begin : g_no_align
        assign misaligned = 1'b0;
    end

    logic                   pick_hit;
    logic [NUM_REGIONS-1:0] pick_cs;
    logic [IDX_W-1:0]       pick_index;
    logic                   dec_err;

    // Lowest-numbered hitting region wins on overlap.
    always_comb begin
        pick_hit   = 1'b0;
        pick_cs    = '0;
        pick_index = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (region_hit[r] && !pick_hit) begin
                pick_hit   = 1'b1;
                pick_cs[r] = 1'b1;
                pick_index = region_index[r];
            end
        end
    end

    assign dec_err = !pick_hit || misaligned;

    logic                   rsp_valid_q, rsp_valid_d;
    logic [NUM_REGIONS-1:0] rsp_cs_q, rsp_cs_d;
    logic [IDX_W-1:0]       rsp_index_q, rsp_index_d;
    logic                   rsp_err_q, rsp_err_d;
    logic                   fault_valid_q, fault_valid_d;
    logic [ADDR_W-1:0]      fault_addr_q, fault_addr_d;
    logic [CNT_W-1:0]       fault_cnt_q, fault_cnt_d;
    logic                   accept;

    assign req_ready_o = !rsp_valid_q || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_cs_d    = rsp_cs_q;
        rsp_index_d = rsp_index_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_cs_d    = dec_err ? '0 : pick_cs;
            rsp_index_d = dec_err ? '0 : pick_index;
            rsp_err_d   = dec_err;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    // A clear and a simultaneous error: the clear applies first, then the error is recorded.
    always_comb begin
        fault_valid_d = fault_valid_q;
        fault_addr_d  = fault_addr_q;
        fault_cnt_d   = fault_cnt_q;
        if (fault_clr_i) begin
            fault_valid_d = 1'b0;
            fault_addr_d  = '0;
            fault_cnt_d   = '0;
        end
        if (accept && dec_err) begin
            if (!fault_valid_d) begin
                fault_valid_d = 1'b1;
                fault_addr_d  = req_addr_i;
            end
            if (fault_cnt_d != {CNT_W{1'b1}}) begin
                fault_cnt_d = fault_cnt_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q   <= 1'b0;
            rsp_cs_q      <= '0;
            rsp_index_q   <= '0;
            rsp_err_q     <= 1'b0;
            fault_valid_q <= 1'b0;
            fault_addr_q  <= '0;
            fault_cnt_q   <= '0;
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_cs_q      <= rsp_cs_d;
            rsp_index_q   <= rsp_index_d;
            rsp_err_q     <= rsp_err_d;
            fault_valid_q <= fault_valid_d;
            fault_addr_q  <= fault_addr_d;
            fault_cnt_q   <= fault_cnt_d;
        end
    end

    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_cs_o      = rsp_cs_q;
    assign rsp_index_o   = rsp_index_q;
    assign rsp_err_o     = rsp_err_q;
    assign fault_valid_o = fault_valid_q;
    assign fault_addr_o  = fault_addr_q;
    assign fault_cnt_o   = fault_cnt_q;

endmodule

// File: tb/tb_addr_decoding_multi.sv
// Directed bench for addr_decoding_multi: default map plus an overlapping, narrow-index variant.
module tb_addr_decoding_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
    logic [31:0] req_addr, fault_addr;
    logic [1:0]  rsp_cs;
    logic [9:0]  rsp_index;
    logic        fault_clr, fault_valid;
    logic [7:0]  fault_cnt;

    logic        req_valid6, req_ready6, rsp_valid6, rsp_ready6, rsp_err6;
    logic [31:0] req_addr6, fault_addr6;
    logic [1:0]  rsp_cs6;
    logic [3:0]  rsp_index6;
    logic        fault_clr6, fault_valid6;
    logic [7:0]  fault_cnt6;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    addr_decoding_multi u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_cs_o      (rsp_cs),
        .rsp_index_o   (rsp_index),
        .rsp_err_o     (rsp_err),
        .fault_clr_i   (fault_clr),
        .fault_valid_o (fault_valid),
        .fault_addr_o  (fault_addr),
        .fault_cnt_o   (fault_cnt)
    );

    addr_decoding_multi #(
        .IDX_W        (4),
        .REGION_BASE  ({32'h0000_18C0, 32'h0000_18C0}),
        .REGION_LIMIT ({32'h0000_1FFF, 32'h0000_1CBF})
    ) u_dut6 (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid6),
        .req_ready_o   (req_ready6),
        .req_addr_i    (req_addr6),
        .rsp_valid_o   (rsp_valid6),
        .rsp_ready_i   (rsp_ready6),
        .rsp_cs_o      (rsp_cs6),
        .rsp_index_o   (rsp_index6),
        .rsp_err_o     (rsp_err6),
        .fault_clr_i   (fault_clr6),
        .fault_valid_o (fault_valid6),
        .fault_addr_o  (fault_addr6),
        .fault_cnt_o   (fault_cnt6)
    );

    task automatic send(input logic [31:0] a);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = a;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic send6(input logic [31:0] a);
        @(negedge clk);
        req_valid6 = 1'b1;
        req_addr6  = a;
        rsp_ready6 = 1'b1;
        @(negedge clk);
        req_valid6 = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0; fault_clr = 1'b0;
        req_valid6 = 1'b0; req_addr6 = '0; rsp_ready6 = 1'b0; fault_clr6 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_err, rsp_cs, rsp_index} !== 14'h0) begin
            errors++;
            $display("FAIL reset_rsp got=%h exp=0", {rsp_valid, rsp_err, rsp_cs, rsp_index});
        end
        checks++;
        if ({fault_valid, fault_addr, fault_cnt} !== 41'h0) begin
            errors++;
            $display("FAIL reset_fault got=%h exp=0", {fault_valid, fault_addr, fault_cnt});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=1", req_ready);
        end
    endtask

    task automatic test_basic_hits;
        send(32'h18C0);
        checks++;
        if ({rsp_valid, rsp_err, rsp_cs, rsp_index} !== {1'b1, 1'b0, 2'b01, 10'h000}) begin
            errors++;
            $display("FAIL hit_18C0 got=%h exp=%h", {rsp_valid, rsp_err, rsp_cs, rsp_index},
                     {1'b1, 1'b0, 2'b01, 10'h000});
        end
        send(32'h1CBC);
        checks++;
        if ({rsp_valid, rsp_err, rsp_cs, rsp_index} !== {1'b1, 1'b0, 2'b01, 10'h0FF}) begin
            errors++;
            $display("FAIL hit_1CBC got=%h exp=%h", {rsp_valid, rsp_err, rsp_cs, rsp_index},
                     {1'b1, 1'b0, 2'b01, 10'h0FF});
        end
        send(32'h1CC0);
        checks++;
        if ({rsp_valid, rsp_err, rsp_cs, rsp_index} !== {1'b1, 1'b0, 2'b10, 10'h000}) begin
            errors++;
            $display("FAIL hit_1CC0 got=%h exp=%h", {rsp_valid, rsp_err, rsp_cs, rsp_index},
                     {1'b1, 1'b0, 2'b10, 10'h000});
        end
        checks++;
        if (fault_valid !== 1'b0) begin
            errors++;
            $display("FAIL hits_no_fault got=%b exp=0", fault_valid);
        end
    endtask

    task automatic test_errors;
        logic [31:0] faddr;
        faddr = 32'h18BC;
        send(32'h18BC);
        checks++;
        if ({rsp_valid, rsp_err, rsp_cs, rsp_index} !== {1'b1, 1'b1, 2'b00, 10'h000}) begin
            errors++;
            $display("FAIL err_18BC got=%h", {rsp_valid, rsp_err, rsp_cs, rsp_index});
        end
        checks++;
        if ({fault_valid, fault_addr, fault_cnt} !== {1'b1, faddr, 8'd1}) begin
            errors++;
            $display("FAIL fault_first got=%h exp=%h", {fault_valid, fault_addr, fault_cnt},
                     {1'b1, faddr, 8'd1});
        end
        send(32'h20C0);
        checks++;
        if ({rsp_err, rsp_cs, rsp_index} !== {1'b1, 2'b00, 10'h000}) begin
            errors++;
            $display("FAIL err_20C0 got=%h", {rsp_err, rsp_cs, rsp_index});
        end
        checks++;
        if ({fault_valid, fault_addr, fault_cnt} !== {1'b1, faddr, 8'd2}) begin
            errors++;
            $display("FAIL fault_second got=%h exp=%h", {fault_valid, fault_addr, fault_cnt},
                     {1'b1, faddr, 8'd2});
        end
        send(32'h18C2);
        checks++;
        if ({rsp_err, rsp_cs, rsp_index} !== {1'b1, 2'b00, 10'h000}) begin
            errors++;
            $display("FAIL misaligned got=%h", {rsp_err, rsp_cs, rsp_index});
        end
        checks++;
        if (fault_cnt !== 8'd3) begin
            errors++;
            $display("FAIL fault_cnt3 got=%0d exp=3", fault_cnt);
        end
    endtask

    task automatic test_back_pressure;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h1900;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_addr = 32'h1CC4;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({req_ready, rsp_valid, rsp_err, rsp_cs, rsp_index} !==
                {1'b0, 1'b1, 1'b0, 2'b01, 10'h010}) begin
                errors++;
                $display("FAIL stall_%0d got=%h", i,
                         {req_ready, rsp_valid, rsp_err, rsp_cs, rsp_index});
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_comb got=%b exp=1", req_ready);
        end
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_err, rsp_cs, rsp_index} !== {1'b1, 1'b0, 2'b10, 10'h001}) begin
            errors++;
            $display("FAIL queued_1CC4 got=%h", {rsp_valid, rsp_err, rsp_cs, rsp_index});
        end
        req_addr = 32'h18C4;
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_err, rsp_cs, rsp_index} !== {1'b1, 1'b0, 2'b01, 10'h001}) begin
            errors++;
            $display("FAIL b2b_18C4 got=%h", {rsp_valid, rsp_err, rsp_cs, rsp_index});
        end
        req_valid = 1'b0;
    endtask

    task automatic test_saturation_clear;
        logic [31:0] faddr;
        faddr = 32'h18BC;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h4000;
        rsp_ready = 1'b1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({fault_valid, fault_addr, fault_cnt} !== {1'b1, faddr, 8'd255}) begin
            errors++;
            $display("FAIL saturate got=%h exp=%h", {fault_valid, fault_addr, fault_cnt},
                     {1'b1, faddr, 8'd255});
        end
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        checks++;
        if ({fault_valid, fault_addr, fault_cnt} !== 41'h0) begin
            errors++;
            $display("FAIL clear got=%h exp=0", {fault_valid, fault_addr, fault_cnt});
        end
        fault_clr = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        @(negedge clk);
        fault_clr = 1'b0;
        req_valid = 1'b0;
        checks++;
        if ({fault_valid, fault_addr, fault_cnt, rsp_err} !== {1'b1, 32'h0, 8'd1, 1'b1}) begin
            errors++;
            $display("FAIL clear_and_err got=%h", {fault_valid, fault_addr, fault_cnt, rsp_err});
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'h18C4;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if ({rsp_valid, rsp_cs, rsp_index} !== {1'b1, 2'b01, 10'h001}) begin
            errors++;
            $display("FAIL pre_reset got=%h", {rsp_valid, rsp_cs, rsp_index});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_err, rsp_cs, rsp_index} !== 14'h0) begin
            errors++;
            $display("FAIL async_reset_rsp got=%h exp=0", {rsp_valid, rsp_err, rsp_cs, rsp_index});
        end
        checks++;
        if ({fault_valid, fault_addr, fault_cnt} !== 41'h0) begin
            errors++;
            $display("FAIL async_reset_fault got=%h exp=0", {fault_valid, fault_addr, fault_cnt});
        end
        @(negedge clk);
        rst_n = 1'b1;
        send(32'h1CC8);
        checks++;
        if ({rsp_valid, rsp_err, rsp_cs, rsp_index} !== {1'b1, 1'b0, 2'b10, 10'h002}) begin
            errors++;
            $display("FAIL post_reset got=%h", {rsp_valid, rsp_err, rsp_cs, rsp_index});
        end
    endtask

    task automatic test_overlap_trunc;
        checks++;
        if (req_ready6 !== 1'b1) begin
            errors++;
            $display("FAIL ov_ready got=%b exp=1", req_ready6);
        end
        send6(32'h18C0);
        checks++;
        if ({rsp_valid6, rsp_err6, rsp_cs6, rsp_index6} !== {1'b1, 1'b0, 2'b01, 4'h0}) begin
            errors++;
            $display("FAIL ov_18C0 got=%h", {rsp_valid6, rsp_err6, rsp_cs6, rsp_index6});
        end
        send6(32'h1900);
        checks++;
        if ({rsp_valid6, rsp_err6, rsp_cs6, rsp_index6} !== {1'b1, 1'b0, 2'b01, 4'h0}) begin
            errors++;
            $display("FAIL trunc_1900 got=%h", {rsp_valid6, rsp_err6, rsp_cs6, rsp_index6});
        end
        send6(32'h1D04);
        checks++;
        if ({rsp_valid6, rsp_err6, rsp_cs6, rsp_index6} !== {1'b1, 1'b0, 2'b10, 4'h1}) begin
            errors++;
            $display("FAIL ov_1D04 got=%h", {rsp_valid6, rsp_err6, rsp_cs6, rsp_index6});
        end
        send6(32'h2000);
        checks++;
        if ({rsp_err6, rsp_cs6, fault_valid6, fault_addr6, fault_cnt6} !==
            {1'b1, 2'b00, 1'b1, 32'h2000, 8'd1}) begin
            errors++;
            $display("FAIL ov_2000 got=%h",
                     {rsp_err6, rsp_cs6, fault_valid6, fault_addr6, fault_cnt6});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_hits();
        test_errors();
        test_back_pressure();
        test_saturation_clear();
        test_reset_mid();
        test_overlap_trunc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
